divisor_restauracion: RTL and testbench
=======================================

Name: divisor_restauracion

Overview:
- Sequential unsigned restoring divider: quotient and remainder of two N-bit operands, one quotient bit per shift/subtract pair.
- Inverse of the shift/add multiplier already in the datapath.
- Contains its own FSM, iteration counter and A/Q/M registers.
- Start/fin handshake matches the multiplier's, so both units can share one sequencer.

Parameters:
- N, 4, operand width in bits (N >= 2).
- CW, 3, iteration-counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  synchronous request; sampled only in REPOSO or FIN.
- dividendo  input  N  dividend; sampled on the accepting edge only.
- divisor  input  N  divisor; sampled on the accepting edge only.
- cociente  output  N  quotient register Q; valid while fin=1.
- resto  output  N  remainder register A[N-1:0]; valid while fin=1.
- ocupado  output  1  high in DESPLAZA and RESTA.
- fin  output  1  high in FIN.
- div0  output  1  divide-by-zero flag; valid while fin=1.

Behaviour:
- Registers:
  - A: N+1 bits (partial remainder).
  - Q: N bits.
  - M: N bits.
  - cnt: CW bits.
  - State encoding: REPOSO, DESPLAZA, RESTA, FIN.
- Reset (rst_n=0, asynchronous, dominates everything):
  - State goes to REPOSO; A, Q, M, cnt and div0 clear to 0.
  - All outputs are 0 during and after reset until the next accepted start.
  - Reset mid-operation aborts the division with no residue.
- REPOSO: ocupado=0, fin=0. On an edge with start=1:
  - divisor != 0: A<=0, Q<=dividendo, M<=divisor, cnt<=N, div0<=0; next state DESPLAZA.
  - divisor == 0: Q<={N{1'b1}}, A<={1'b0,dividendo}, div0<=1; next state FIN. fin rises 1 cycle after the accepting edge.
- DESPLAZA: {A,Q}<={A,Q}<<1, Q[0]<=0; next state RESTA.
- RESTA:
  - Compute d = A - {1'b0,M} in N+2 bits.
  - If d >= 0 (sign bit clear): A<=d[N:0], Q[0]<=1. Otherwise A unchanged, Q[0]<=0.
  - cnt<=cnt-1. If cnt==1, next state FIN; otherwise DESPLAZA.
- FIN: fin=1; cociente, resto and div0 are held stable.
  - start=1 re-accepts a new operation exactly as in REPOSO (back-to-back operation permitted).
  - start=0 stays in FIN indefinitely.
- Latency: fin is high starting 2N cycles after the accepting edge (8 cycles for N=4).
- start in DESPLAZA or RESTA is ignored; operands and registers are not disturbed.
- Invariants:
  - A < 2*M after every DESPLAZA, so N+1 bits never overflow.
  - A < M after every RESTA.
- Outputs come directly from registers; no combinational path from inputs to outputs.
- In DESPLAZA/RESTA, cociente and resto show intermediate values; these are not meaningful.

Test Plan:
- N=4: 13/4 with a 1-cycle start pulse -> ocupado high 8 cycles; fin high on the 8th edge after acceptance; cociente=3, resto=1, div0=0.
- N=4 boundaries: 15/1 -> cociente=15, resto=0. 5/7 -> cociente=0, resto=5. 0/3 -> 0, 0. 15/15 -> 1, 0.
- N=4: 9/0 -> fin one cycle after acceptance, div0=1, cociente=4'hF, resto=9, ocupado never asserted.
- start held high throughout 13/4 while dividendo changes to 2 mid-operation -> result still 3/1. A second start while in FIN (6/4) restarts immediately: fin drops next cycle and returns 8 cycles later with cociente=1, resto=2.
- rst_n pulsed low for a partial cycle at cycle 4 of a division -> all outputs 0 immediately (asynchronously), state REPOSO. Next start 14/3 -> cociente=4, resto=2.
- N=8: 255/16 -> cociente=15, resto=15 after 16 cycles. 200/201 -> cociente=0, resto=200. Randomized sweep over 1000 operand pairs checked against / and %.

Source files
------------

// File: rtl/divisor_restauracion.sv
// Sequential unsigned restoring divider: one quotient bit per shift/subtract pair.
// Start/fin handshake mirrors the shift/add multiplier so both share one sequencer.
module divisor_restauracion #(
   parameter int N  = 4,
   parameter int CW = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividendo,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] cociente,
   output logic [N-1:0] resto,
   output logic         ocupado,
   output logic         fin,
   output logic         div0
);

   typedef enum logic [1:0] {
      REPOSO,
      DESPLAZA,
      RESTA,
      FIN
   } estado_t;

   estado_t estado;
   estado_t siguiente;

   logic [N:0]    a;
   logic [N-1:0]  q;
   logic [N-1:0]  m;
   logic [CW-1:0] cnt;
   logic [N+1:0]  d;
   logic          acepta;

   assign acepta = start && (estado == REPOSO || estado == FIN);
   assign d      = {1'b0, a} - {2'b00, m};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= REPOSO;
      end else begin
         estado <= siguiente;
      end
   end

   always_comb begin
      siguiente = estado;
      unique case (estado)
         REPOSO, FIN: begin
            if (start) begin
               siguiente = (divisor == '0) ? FIN : DESPLAZA;
            end
         end
         DESPLAZA: siguiente = RESTA;
         RESTA: begin
            siguiente = (cnt == CW'(1)) ? FIN : DESPLAZA;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a    <= '0;
         q    <= '0;
         m    <= '0;
         cnt  <= '0;
         div0 <= 1'b0;
      end else if (acepta) begin
         // Divide-by-zero short-circuits straight to FIN with saturated quotient
         if (divisor == '0) begin
            q    <= '1;
            a    <= {1'b0, dividendo};
            div0 <= 1'b1;
         end else begin
            a    <= '0;
            q    <= dividendo;
            m    <= divisor;
            cnt  <= CW'(N);
            div0 <= 1'b0;
         end
      end else if (estado == DESPLAZA) begin
         {a, q} <= {a[N-1:0], q, 1'b0};
      end else if (estado == RESTA) begin
         if (!d[N+1]) begin
            a <= d[N:0];
         end
         q[0] <= ~d[N+1];
         cnt  <= cnt - CW'(1);
      end
   end

   assign cociente = q;
   assign resto    = a[N-1:0];
   assign ocupado  = (estado == DESPLAZA) || (estado == RESTA);
   assign fin      = (estado == FIN);

endmodule

// File: tb/tb_divisor_restauracion.sv
// Bench for divisor_restauracion: N=4 and N=8 instances checked against / and %.
// Directed boundary cases plus a randomized operand sweep.
module tb_divisor_restauracion;

   logic       clk;
   logic       rst_n;
   logic       st4, st8;
   logic [3:0] dd4, dv4, q4, r4;
   logic [7:0] dd8, dv8, q8, r8;
   logic       oc4, fin4, z4;
   logic       oc8, fin8, z8;

   bit         wide;
   logic [7:0] o_q, o_r;
   logic       o_oc, o_fin, o_z;

   int checks;
   int failures;

   divisor_restauracion #(.N(4), .CW(3)) u4 (
      .clk(clk), .rst_n(rst_n), .start(st4),
      .dividendo(dd4), .divisor(dv4),
      .cociente(q4), .resto(r4),
      .ocupado(oc4), .fin(fin4), .div0(z4)
   );

   divisor_restauracion #(.N(8), .CW(4)) u8 (
      .clk(clk), .rst_n(rst_n), .start(st8),
      .dividendo(dd8), .divisor(dv8),
      .cociente(q8), .resto(r8),
      .ocupado(oc8), .fin(fin8), .div0(z8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      if (wide) begin
         o_q   = q8;
         o_r   = r8;
         o_oc  = oc8;
         o_fin = fin8;
         o_z   = z8;
      end else begin
         o_q   = {4'h0, q4};
         o_r   = {4'h0, r4};
         o_oc  = oc4;
         o_fin = fin4;
         o_z   = z4;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_fin(output int lat, output int occ);
      lat = 0;
      occ = 0;
      while (!o_fin && lat < 40) begin
         occ += int'(o_oc);
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic op(input logic [7:0] a, input logic [7:0] b);
      int n, lat, occ;
      logic [7:0] mask, eq, er;
      n    = wide ? 8 : 4;
      mask = wide ? 8'hFF : 8'h0F;
      if (wide) begin
         dd8 = a; dv8 = b; st8 = 1'b1;
      end else begin
         dd4 = a[3:0]; dv4 = b[3:0]; st4 = 1'b1;
      end
      @(posedge clk);
      #1;
      st4 = 1'b0;
      st8 = 1'b0;
      wait_fin(lat, occ);
      eq = (b == 0) ? mask : a / b;
      er = (b == 0) ? a : a % b;
      chk("lat", lat, (b == 0) ? 0 : 2 * n);
      chk("ocupado_cycles", occ, (b == 0) ? 0 : 2 * n);
      chk("cociente", o_q, eq);
      chk("resto", o_r, er);
      chk("div0", o_z, b == 0);
   endtask

   initial begin
      int lat, occ;
      checks   = 0;
      failures = 0;
      wide     = 1'b0;
      rst_n    = 1'b0;
      st4 = 0; st8 = 0;
      dd4 = 0; dv4 = 0; dd8 = 0; dv8 = 0;
      #12;
      chk("rst_q", q4, 0);
      chk("rst_r", r4, 0);
      chk("rst_oc", oc4, 0);
      chk("rst_fin", fin4, 0);
      chk("rst_div0", z4, 0);
      chk("rst_fin8", fin8, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      op(13, 4);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_fin", o_fin, 1);
      chk("hold_q", o_q, 3);
      chk("hold_r", o_r, 1);
      op(15, 1);
      op(5, 7);
      op(0, 3);
      op(15, 15);
      op(9, 0);
      op(13, 4);

      // start held high; dividend changes mid-operation
      dd4 = 13; dv4 = 4; st4 = 1'b1;
      @(posedge clk);
      #1;
      lat = 0;
      while (!fin4 && lat < 40) begin
         if (lat == 3) dd4 = 2;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("held_lat", lat, 8);
      chk("held_q", q4, 3);
      chk("held_r", r4, 1);
      dd4 = 6; dv4 = 4;
      @(posedge clk);
      #1;
      st4 = 1'b0;
      chk("restart_fin_drop", fin4, 0);
      wait_fin(lat, occ);
      chk("restart_lat", lat + 1, 9);
      chk("restart_q", q4, 1);
      chk("restart_r", r4, 2);

      // asynchronous abort mid-division
      dd4 = 13; dv4 = 4; st4 = 1'b1;
      @(posedge clk);
      #1;
      st4 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_q", q4, 0);
      chk("abort_r", r4, 0);
      chk("abort_oc", oc4, 0);
      chk("abort_fin", fin4, 0);
      chk("abort_div0", z4, 0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_abort_oc", oc4, 0);
      chk("post_abort_fin", fin4, 0);
      op(14, 3);

      repeat (100) op(8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));

      wide = 1'b1;
      op(255, 16);
      op(200, 201);
      op(77, 0);
      repeat (1000) op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
